// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a length-prefixed byte stream over valid/ready, assembles
// little-endian words and issues one write strobe per word at an
// auto-incremented word-aligned byte address. The core is held in reset
// until a load completes successfully.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match the data bytes for the load to succeed.
module imem_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // Word counters must hold DEPTH itself (word_idx reaches count).
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_FIN,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] count;
  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;
  logic             xfer;
  logic             len_bad;
  logic             last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // A byte moves only when both sides agree in the same cycle.
  assign xfer      = byte_valid && byte_ready;
  // Zero-length and over-capacity programs are rejected up front.
  assign len_bad   = (byte_data == 8'd0) || (byte_data > DEPTH_B);
  assign last_word = (word_idx == (count - 1'b1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the handshake and write strobe, which depend on state alone.
  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_LEN;
        end
      end
      S_LEN: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          next_state = len_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && (byte_idx == 2'd3)) begin
          next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = S_CHK;
`else
          next_state = S_FIN;
`endif
        end else begin
          next_state = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          next_state = (byte_data == csum) ? S_FIN : S_ERR;
        end
      end
`endif
      S_FIN:   next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Word assembly, addressing and counters; wr_addr/wr_data change only when a word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx <= '0;
      count    <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        S_LEN: begin
          if (xfer && !len_bad) begin
            count    <= byte_data[IDX_W-1:0];
            byte_idx <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: begin
                wr_data <= WIDTH'({byte_data, word_buf});
                wr_addr <= WIDTH'({word_idx, 2'b00});
              end
            endcase
          end
        end
        S_WRITE: begin
          word_idx <= word_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over data bytes only; the length byte never enters it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if ((state == S_IDLE) && start) begin
      csum <= '0;
    end else if ((state == S_DATA) && xfer) begin
      csum <= csum ^ byte_data;
    end
  end
`endif

  // Status flags: done/error are sticky until the next accepted start; core_hold drops only on success.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b1;
          end
        end
        S_FIN: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          core_hold <= 1'b0;
        end
        S_ERR: begin
          busy      <= 1'b0;
          error     <= 1'b1;
          core_hold <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams with random
// valid gaps, checked against a stream-level reference model.
// Honours IMEM_LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_loader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 21;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = 8'h00;
  logic             byte_ready;
  logic             wr_en;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             core_hold;
  logic             busy;
  logic             done;
  logic             error;

  imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_hold(core_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed writes
  int          cyc = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
      check("ready_in_write", {31'b0, byte_ready}, 32'd0);
    end
  end

  // Stimulus stream and reference expectations
  logic [7:0]  stim[$];
  logic [31:0] ea_q[$];
  logic [31:0] ed_q[$];
  logic        exp_done;
  logic        exp_err;

  // Reference: interpret the whole stream by its format rules.
  task automatic run_model();
    int n;
    logic [7:0] x;
    logic [31:0] w;
    ea_q.delete();
    ed_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'(stim[0]);
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = 32'(stim[1+4*i]) + (32'(stim[2+4*i]) << 8) +
          (32'(stim[3+4*i]) << 16) + (32'(stim[4+4*i]) << 24);
      ea_q.push_back(32'(i * 4));
      ed_q.push_back(w);
      x = x ^ stim[1+4*i] ^ stim[2+4*i] ^ stim[3+4*i] ^ stim[4+4*i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (stim[1+4*n] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic build_basic(input logic [7:0] cs_byte);
    stim = '{8'h03, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00,
             8'h93, 8'h83, 8'h71, 8'hFF};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(cs_byte);
`else
    if (cs_byte == 8'h00) stim.push_back(8'h00);
    if (cs_byte == 8'h00) void'(stim.pop_back());
`endif
  endtask

  task automatic build_words(input int n, input bit seq, input bit bad_cs);
    logic [31:0] w;
    logic [7:0] x;
    stim.delete();
    stim.push_back(8'(n));
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = seq ? 32'(i) : $urandom;
      for (int b = 0; b < 4; b++) begin
        stim.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(x ^ {7'b0, bad_cs});
`else
    if (bad_cs) x = 8'h00;
`endif
  endtask

  task automatic start_load(input string tag);
    @(negedge clk);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_on_start"}, {31'b0, busy}, 32'd1);
    check({tag, "_hold_on_start"}, {31'b0, core_hold}, 32'd1);
    check({tag, "_done_cleared"}, {31'b0, done}, 32'd0);
    check({tag, "_err_cleared"}, {31'b0, error}, 32'd0);
  endtask

  // Sends the first nbytes of stim with random 0..max_gap idle cycles before each byte.
  task automatic send(input int max_gap, input int nbytes);
    int w;
    int g;
    bit to;
    to = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = stim[i];
      w = 0;
      while (!byte_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) to = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    check("handshake_timeout", {31'b0, to}, 32'd0);
  endtask

  task automatic compare(input string tag, input bit spacing);
    int w;
    int n;
    w = 0;
    while (busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_idle_timeout"}, {31'b0, (w >= 50)}, 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_nwrites"}, wa_q.size(), ea_q.size());
    n = (wa_q.size() < ea_q.size()) ? wa_q.size() : ea_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wa_q[i], ea_q[i]);
      check($sformatf("%s_data%0d", tag, i), wd_q[i], ed_q[i]);
      if (spacing && i > 0)
        check($sformatf("%s_gap%0d", tag, i), wc_q[i] - wc_q[i-1], 32'd5);
    end
    check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
    check({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
    check({tag, "_core_hold"}, {31'b0, core_hold}, {31'b0, ~exp_done});
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'd0);
    check({tag, "_wr_en"}, {31'b0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, wr_addr, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_error"}, {31'b0, error}, 32'd0);
    check({tag, "_core_hold"}, {31'b0, core_hold}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load, valid held high
    start_load("basic");
    build_basic(8'h8E);
    run_model();
    send(0, stim.size());
    compare("basic", 1'b1);

    // Bad lengths
    start_load("len22");
    stim = '{8'h16};
    run_model();
    send(0, 1);
    compare("len22", 1'b0);
    start_load("len0");
    stim = '{8'h00};
    run_model();
    send(0, 1);
    compare("len0", 1'b0);

    // Backpressure plus a stray start mid-load
    start_load("bp");
    build_basic(8'h8E);
    run_model();
    fork
      send(3, stim.size());
      begin
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    compare("bp", 1'b0);

    // Reset after two bytes of word 1
    start_load("rstmid");
    build_basic(8'h8E);
    send(0, 7);
    rst_n = 1'b0;
    #1;
    check_reset("rstmid");
    nw = wa_q.size();
    check("rstmid_writes_before", nw, 32'd1);
    repeat (3) @(negedge clk);
    check("rstmid_no_write_in_reset", wa_q.size(), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    start_load("reload");
    build_basic(8'h8E);
    run_model();
    send(0, stim.size());
    compare("reload", 1'b1);

    // Full depth
    start_load("full");
    build_words(DEPTH, 1'b1, 1'b0);
    run_model();
    send(0, stim.size());
    compare("full", 1'b1);
    check("full_last_addr", (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 32'hFFFF_FFFF, 32'h50);

`ifdef IMEM_LOADER_CHECKSUM_EN
    start_load("csbad");
    build_basic(8'h8F);
    run_model();
    send(0, stim.size());
    compare("csbad", 1'b1);
    check("csbad_writes", wa_q.size(), 32'd3);
`endif

    // Randomized loads
    for (int t = 0; t < 8; t++) begin
      start_load($sformatf("rnd%0d", t));
      build_words(int'($urandom_range(1, DEPTH)), 1'b0, ($urandom_range(0, 3) == 0));
      run_model();
      send(int'($urandom_range(0, 3)), stim.size());
      compare($sformatf("rnd%0d", t), 1'b0);
    end
    for (int t = 0; t < 3; t++) begin
      start_load($sformatf("rndbad%0d", t));
      stim = '{8'($urandom_range(DEPTH + 1, 255))};
      run_model();
      send(2, 1);
      compare($sformatf("rndbad%0d", t), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the RV32I instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word goes out as a one-cycle write strobe at an auto-incremented, word-aligned byte address. While a load is pending or in progress, it holds the core in reset, so instruction fetch only starts once the program is fully written.

Parameters:
WIDTH, 32, instruction word and address width
DEPTH, 21, maximum number of instruction words (memory indices 0..DEPTH-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that begins a load; honoured only in IDLE
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_addr  output  WIDTH  byte address of the word being written (word_idx<<2)
wr_data  output  WIDTH  assembled instruction word
core_hold  output  1  active-high reset request to the core
busy  output  1  load in progress
done  output  1  sticky: last load completed successfully
error  output  1  sticky: last load aborted

Behaviour:
- Reset (rst_n=0, async): state=IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, core_hold=1. Any partial word is discarded. Words already written stay in memory.
- A byte transfers only when byte_valid=1 and byte_ready=1 in the same cycle. byte_valid while byte_ready=0 is ignored and nothing is consumed.
- Stream format: one length byte N (word count), then N*4 data bytes, least-significant byte first. With CHECKSUM_EN, one checksum byte follows the data.
- IDLE: byte_ready=0. On start: clear done/error, core_hold=1, busy=1, word_idx=0, go to LEN.
- LEN: byte_ready=1. On transfer:
  - If N=0 or N>DEPTH: go to ERR.
  - Otherwise latch count=N, byte_idx=0, go to DATA.
- DATA: byte_ready=1. Byte k of the word (k=0..3) goes into wr_data[8k+7:8k]. The transfer of byte 3 moves the state to WRITE.
- WRITE: byte_ready=0. wr_en=1 for exactly this cycle, wr_addr=word_idx<<2, wr_data stable. Write latency is one cycle after the 4th byte handshake. Then word_idx increments:
  - If word_idx reaches count: go to FIN, or CHK when CHECKSUM_EN is defined.
  - Otherwise go back to DATA.
- FIN: single cycle. Sets done=1, core_hold=0, busy=0, then returns to IDLE.
- ERR: single cycle. Sets error=1, busy=0, and leaves core_hold=1, then returns to IDLE.
- wr_addr and wr_data hold their last values outside WRITE.
- start while not in IDLE is ignored.
- start in IDLE after done=1 reloads the program: the core is held again and done is cleared.
- Maximum load: N=DEPTH, last wr_addr=(DEPTH-1)*4=0x50. The 5-bit word_idx never wraps.
- Throughput: with byte_valid held high, one word takes 5 cycles (4 transfers + WRITE).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN
- Defined:
  - A running XOR of all data bytes is kept. It is cleared on start and excludes the length byte.
  - After the last WRITE the state moves to CHK with byte_ready=1.
  - The received byte is compared with the XOR: a match goes to FIN, a mismatch goes to ERR.
  - On mismatch, core_hold stays 1 even though words were already written.
- Undefined: no CHK state and no checksum byte. The state goes from the last WRITE directly to FIN.

Test Plan:
- Basic load (macro off): reset, start, stream 03,13,01,50,00,93,01,C0,00,93,83,71,FF with byte_valid held high. Required:
  - wr_en pulses at 0x0/0x00500113, 0x4/0x00C00193, 0x8/0xFF718393.
  - done=1, core_hold=0, error=0.
  - Exactly 3 wr_en pulses, 5 cycles apart.
- Bad length: start, length 0x16 (22) -> error=1, no wr_en pulse, core_hold=1. Repeat with length 0x00 -> same response.
- Backpressure and ignore: same stream as the basic load with random 0-3 cycle gaps on byte_valid, plus a start pulse mid-load. Required: identical writes and data, the start pulse has no effect, and byte_ready=0 in every WRITE cycle.
- Reset mid-word: assert rst_n=0 after 2 data bytes of word 1. Required:
  - All outputs return to reset values and no wr_en occurs.
  - A new start plus the full basic stream then loads correctly.
- Full depth: N=21 with words 0x0..0x14. Required: last write at wr_addr=0x50, then done=1.
- Checksum (macro on): the basic stream followed by 0x8E -> done=1, core_hold=0. The same stream followed by 0x8F -> error=1, core_hold=1, and 3 writes already issued.
